fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_rom.sv | 12 +
 rtl/fetch_queue.sv | 112 +++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: the queue entry carried to decode and the
// 2-bit branch predictor counter with its saturating update.
package fetch_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
  } entry_t;

  function automatic ctr_t ctr_next(ctr_t c, logic taken);
    if (taken) return (c == CTR_ST) ? CTR_ST : c + 2'd1;
    return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular queue with occupancy count; clear empties it in one edge and takes
// priority over push/pop. Callers never push into a full queue without popping.
module fetch_fifo #(
  parameter int  DEPTH  = 4,
  parameter type item_t = logic
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  item_t                      din,
  output item_t                      dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  item_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // NOTE: the storage array has no reset, only pointers and count do; dout is
  // forced to zero while empty so stale or uninitialised slots never leak out.
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_rom.sv
// Combinational instruction memory holding a synthetic straight-line program:
// word i is "addi x0, x0, i", so every fetched word identifies its own slot.
module fetch_rom #(
  parameter int NUM_INST = 128
) (
  input  logic [$clog2(NUM_INST)-1:0] idx,
  output logic [31:0]                 instr
);

  assign instr = 32'h0000_0013 | (32'(idx) << 20);

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: PC register, direct-mapped BTB with 2-bit counters, instruction
// ROM and a fetch queue feeding decode; execute-stage mispredicts flush and redirect.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          NUM_INST    = 128,
  parameter int          QDEPTH      = 4,
  parameter int          BTB_ENTRIES = 16,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_taken,
  input  logic        res_pred,
  input  logic [31:0] res_target,
  output logic        fd_valid,
  output logic [31:0] fd_instr,
  output logic [31:0] fd_pc,
  output logic        fd_pred,
  output logic        flush
);

  localparam int IMEM_AW = $clog2(NUM_INST);
  localparam int IDX_W   = $clog2(BTB_ENTRIES);
  localparam int TAG_W   = 30 - IDX_W;
  localparam int CW      = $clog2(QDEPTH + 1);

  logic [31:0]      pc;
  logic [31:0]      instr;
  logic             btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
  logic [31:0]      btb_target [BTB_ENTRIES];
  ctr_t             ctr        [BTB_ENTRIES];
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] res_idx;
  logic             pred;
  logic             pop;
  logic             push;
  logic             full;
  logic             empty;
  logic [CW-1:0]    q_count;
  entry_t           fetched;
  entry_t           head;

  assign idx     = pc[2 +: IDX_W];
  assign res_idx = res_pc[2 +: IDX_W];

  // Lookup reads the registered BTB, so a same-cycle update is only seen next cycle.
  assign pred  = btb_valid[idx] && (btb_tag[idx] == pc[31 -: TAG_W]) && (ctr[idx] >= CTR_WT);
  assign flush = res_valid && (res_taken != res_pred);

  assign fd_valid = (q_count != '0);
  assign pop      = fd_valid && !stall;
  assign push     = !full || pop;
  assign fetched  = '{instr: instr, pc: pc, pred: pred};

  assign fd_instr = head.instr;
  assign fd_pc    = head.pc;
  assign fd_pred  = head.pred;

  fetch_rom #(.NUM_INST(NUM_INST)) u_rom (
    .idx   (pc[2 +: IMEM_AW]),
    .instr (instr)
  );

  fetch_fifo #(.DEPTH(QDEPTH), .item_t(entry_t)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push && !flush),
    .pop   (pop && !flush),
    .clear (flush),
    .din   (fetched),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (q_count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      pc <= RESET_PC;
    else if (flush) pc <= res_taken ? res_target : res_pc + 32'd4;
    else if (push)  pc <= pred ? btb_target[idx] : pc + 32'd4;
  end

  // NOTE: non-blocking updates keep every read this cycle on pre-edge values,
  // which is what gives the lookup its read-before-update behaviour.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
        ctr[i]       <= CTR_WNT;
      end
    end else if (res_valid) begin
      ctr[res_idx] <= ctr_next(ctr[res_idx], res_taken);
      if (res_taken) btb_valid[res_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (res_valid && res_taken) begin
      btb_tag[res_idx]    <= res_pc[31 -: TAG_W];
      btb_target[res_idx] <= res_target;
    end
  end

  // empty and count describe the same occupancy from two angles
  assert property (@(posedge clk) disable iff (!rstn) empty == (q_count == '0));

endmodule
